// File: rtl/riscv_run_controller.sv
// riscv_run_controller: sequences core reset, then watches tohost stores, PC stalls and the cycle budget to latch a verdict
module riscv_run_controller #(
  parameter int RST_CYCLES = 2,
  parameter int MAX_CYCLES = 5,
  parameter int HALT_STABLE = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W = 32,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR = 'h100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] core_pc,
  input  logic              core_mem_we,
  input  logic [ADDR_W-1:0] core_mem_addr,
  input  logic [DATA_W-1:0] core_mem_wdata,
  output logic              core_rst_n,
  output logic              running,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [DATA_W-1:0] exit_code
);
  typedef enum logic [2:0] {IDLE, HOLD, RUN, PASS, FAIL, TIMEOUT} state_t;
  state_t state, state_n;
  logic [31:0] hold_cnt, halt_cnt, halt_inc;
  logic [ADDR_W-1:0] prev_pc;
  logic [CNT_W-1:0] cnt_inc;
  logic [DATA_W-1:0] code_n;
  logic term, launch, first, tohost, halt, tmo;
  assign term = (state == PASS) || (state == FAIL) || (state == TIMEOUT);
  assign launch = start && ((state == IDLE) || term);
  always_comb begin
    cnt_inc = &cycle_count ? cycle_count : cycle_count + 1'b1;
    first = cycle_count == '0;
    // the very first RUN cycle has no valid prev_pc to compare against
    halt_inc = (!first && core_pc == prev_pc) ? halt_cnt + 32'd1 : 32'd0;
    tohost = core_mem_we && core_mem_addr == TOHOST_ADDR;
    halt = HALT_STABLE != 0 && halt_inc == 32'(HALT_STABLE);
    tmo = MAX_CYCLES != 0 && cnt_inc == CNT_W'(MAX_CYCLES);
    code_n = tohost ? (core_mem_wdata == DATA_W'(1) ? '0 : core_mem_wdata >> 1) : halt ? '1 : '0;
    state_n = state;
    if (launch)
      state_n = HOLD;
    else if (state == HOLD && hold_cnt == 32'(RST_CYCLES - 1))
      state_n = RUN;
    else if (state == RUN)
      state_n = tohost ? (core_mem_wdata == DATA_W'(1) ? PASS : FAIL) : halt ? FAIL : tmo ? TIMEOUT : RUN;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // outputs are registered copies of the state being entered
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hold_cnt <= '0;
      halt_cnt <= '0;
      prev_pc <= '0;
      core_rst_n <= 1'b0;
      running <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      fail <= 1'b0;
      timeout <= 1'b0;
      cycle_count <= '0;
      exit_code <= '0;
    end else begin
      hold_cnt <= (state == HOLD) ? hold_cnt + 32'd1 : 32'd0;
      core_rst_n <= state_n == RUN;
      running <= state_n == RUN;
      done <= (state_n == PASS) || (state_n == FAIL) || (state_n == TIMEOUT);
      pass <= state_n == PASS;
      fail <= state_n == FAIL;
      timeout <= state_n == TIMEOUT;
      if (launch) begin
        cycle_count <= '0;
        exit_code <= '0;
        halt_cnt <= '0;
      end else if (state == RUN) begin
        cycle_count <= cnt_inc;
        halt_cnt <= halt_inc;
        prev_pc <= core_pc;
        exit_code <= code_n;
      end
    end
endmodule
